// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative integer multiply/divide unit for the HI/LO path.
// Supports signed/unsigned multiply (radix-2 Booth) and signed/unsigned
// divide (restoring). Every op has the same latency: done arrives WIDTH+1 edges
// after the start edge.
// Ports:
//   clk, reset (async, active-low)
//   start/op/a/b : request, sampled only while idle
//   busy, done   : handshake (done is a one-cycle pulse)
//   div_zero     : last completed op was a divide by zero
//   hi, lo       : product halves, or remainder/quotient
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned AW = WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t state, state_next;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [AW-1:0]    m_q;    // multiplicand (Booth) or divisor magnitude
  logic [AW-1:0]    p_q;    // Booth upper accumulator / partial remainder
  logic [WIDTH-1:0] q_q;    // multiplier bits / dividend-quotient bits
  logic             qm1_q;  // Booth q-1 bit
  logic [CNT_W-1:0] cnt;

  logic [AW-1:0]    p_sum;
  logic [AW-1:0]    r_sh, r_diff;
  logic             r_ok;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_dz;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (start) state_next = S_RUN;
      S_RUN:    if (cnt == CNT_W'(WIDTH - 1)) state_next = S_FINISH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Booth step: add/subtract multiplicand according to {Q[0], q-1}
  always_comb begin
    p_sum = p_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   p_sum = p_q + m_q;
      2'b10:   p_sum = p_q - m_q;
      default: p_sum = p_q;
    endcase
  end

  // Restoring divide step; r_sh < 2*divisor so the difference fits AW bits signed
  always_comb begin
    r_sh   = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    r_diff = r_sh - m_q;
    r_ok   = ~r_diff[AW-1];
  end

  // Final result with sign correction
  always_comb begin
    res_hi = p_q[WIDTH-1:0];
    res_lo = q_q;
    res_dz = 1'b0;
    if (!op_q[1]) begin
      // Booth treats b as signed; an unsigned b with MSB set needs a*2^WIDTH added
      if (op_q[0] && b_q[WIDTH-1]) res_hi = p_q[WIDTH-1:0] + a_q;
    end else if (b_q == '0) begin
      res_dz = 1'b1;
      res_hi = a_q;
      res_lo = '1;
    end else if (!op_q[0]) begin
      if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) res_lo = ~q_q + WIDTH'(1);
      if (a_q[WIDTH-1])                res_hi = ~p_q[WIDTH-1:0] + WIDTH'(1);
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      p_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      busy <= (state_next != S_IDLE);
      done <= (state == S_FINISH);
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            p_q   <= '0;
            qm1_q <= 1'b0;
            cnt   <= '0;
            if (op[1]) begin
              m_q <= {1'b0, (op[0] ? b : mag(b))};
              q_q <= op[0] ? a : mag(a);
            end else begin
              m_q <= {(op[0] ? 1'b0 : a[WIDTH-1]), a};
              q_q <= b;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (!op_q[1]) begin
            p_q   <= {p_sum[AW-1], p_sum[AW-1:1]};
            q_q   <= {p_sum[0], q_q[WIDTH-1:1]};
            qm1_q <= q_q[0];
          end else begin
            p_q <= r_ok ? r_diff : r_sh;
            q_q <= {q_q[WIDTH-2:0], r_ok};
          end
        end
        S_FINISH: begin
          hi       <= res_hi;
          lo       <= res_lo;
          div_zero <= res_dz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed cases plus random
// ops checked against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] prev_hi, prev_lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero
  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output logic edz);
    longint sx, sy, sq, sr;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    edz = 1'b0;
    case (o)
      2'b00: begin p = 64'(sx * sy); eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = {32'b0, x} * {32'b0, y}; eh = p[63:32]; el = p[31:0]; end
      default: begin
        if (y == 0) begin
          edz = 1'b1; eh = x; el = '1;
        end else if (o == 2'b10) begin
          sq = sx / sy; sr = sx % sy;
          el = sq[31:0]; eh = sr[31:0];
        end else begin
          el = x / y; eh = x % y;
        end
      end
    endcase
  endtask

  // Called at a negedge; returns #1 after the accepting edge with inputs scrambled
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  // Issue an op, wait for done and check everything; ends at the done-cycle negedge.
  // pk >= 0 injects a stray DIV start while busy at that cycle.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int pk);
    logic [W-1:0] eh, el;
    logic edz;
    int k;
    bit busy_ok, hold_ok;
    model(o, x, y, eh, el, edz);
    issue(o, x, y);
    k = 0; busy_ok = 1; hold_ok = 1;
    @(negedge clk);
    while (!done && k < 100) begin
      if (busy !== 1'b1) busy_ok = 0;
      if (hi !== prev_hi || lo !== prev_lo) hold_ok = 0;
      if (k == pk) begin
        start = 1'b1; op = 2'b10; a = 1; b = 1;
      end else if (k == pk + 1) begin
        start = 1'b0;
      end
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(k), 64'(W + 1));
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_busy_low"}, 64'(busy), 64'(0));
    chk({tag, "_busy_held"}, 64'(busy_ok), 64'(1));
    chk({tag, "_hold"}, 64'(hold_ok), 64'(1));
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    chk({tag, "_dz"}, 64'(div_zero), 64'(edz));
    prev_hi = eh; prev_lo = el;
  endtask

  task automatic done_low(input string tag);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] rx, ry;
    bit seen;
    int k;

    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    prev_hi = '0; prev_lo = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_dz", 64'(div_zero), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    do_op("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'd7, -1);
    chk("mult_m3x7_hi_c", 64'(hi), 64'hFFFFFFFF);
    chk("mult_m3x7_lo_c", 64'(lo), 64'hFFFFFFEB);
    done_low("mult_m3x7");

    do_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    chk("multu_max_hi_c", 64'(hi), 64'hFFFFFFFE);
    chk("multu_max_lo_c", 64'(lo), 64'h00000001);
    done_low("multu_max");
    do_op("mult_m1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    chk("mult_m1_hi_c", 64'(hi), 64'h0);
    done_low("mult_m1");

    do_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, -1);
    chk("div_m7_2_lo_c", 64'(lo), 64'hFFFFFFFD);
    chk("div_m7_2_hi_c", 64'(hi), 64'hFFFFFFFF);
    done_low("div_m7_2");
    do_op("divu_7_2", 2'b11, 32'd7, 32'd2, -1);
    done_low("divu_7_2");
    do_op("div_min", 2'b10, 32'h80000000, 32'hFFFFFFFF, -1);
    chk("div_min_lo_c", 64'(lo), 64'h80000000);
    done_low("div_min");

    do_op("divu_z", 2'b11, 32'h64, 32'h0, -1);
    chk("divu_z_dz_c", 64'(div_zero), 64'(1));
    done_low("divu_z");
    do_op("mult_2x3", 2'b00, 32'd2, 32'd3, -1);
    chk("mult_2x3_lo_c", 64'(lo), 64'd6);
    done_low("mult_2x3");

    // Stray start while busy, then back-to-back start in the done cycle
    do_op("ign", 2'b00, 32'd5, 32'd6, 10);
    chk("ign_lo_c", 64'(lo), 64'd30);
    do_op("b2b", 2'b01, 32'h12345678, 32'h9ABCDEF0, -1);
    done_low("b2b");

    // Asynchronous reset mid-operation
    issue(2'b00, 32'd1234, 32'd5678);
    for (int i = 0; i < 15; i++) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_hi", 64'(hi), 64'(0));
    chk("arst_lo", 64'(lo), 64'(0));
    chk("arst_dz", 64'(div_zero), 64'(0));
    prev_hi = '0; prev_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("arst_no_done", 64'(seen), 64'(0));
    do_op("arst_fresh", 2'b00, 32'hFFFFFF00, 32'd300, -1);
    done_low("arst_fresh");

    // Random ops with boundary operands mixed in
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case (i % 6)
        0: ry = '0;
        1: rx = 32'h80000000;
        2: ry = 32'hFFFFFFFF;
        3: ry = 32'($urandom_range(1, 9));
        default: ;
      endcase
      do_op($sformatf("rnd%0d_op%0d", i, ro), ro, rx, ry, -1);
      if (i % 4 == 0) done_low($sformatf("rnd%0d", i));
    end
    done_low("rnd_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
